// File: rtl/fuzz_lane_pipe_pkg.sv
// Shared types and helpers for the fuzz lane pipeline.
// FUZZ_SIG_EN (defined elsewhere) enables the output signature that uses fold32.
package fuzz_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_XOR  = 2'd1,
    MODE_SUB  = 2'd2,
    MODE_ROT  = 2'd3
  } mode_e;

  localparam logic [31:0] SIG_RESET = 32'hFFFF_FFFF;

  // Widest out_data the fold accepts; callers zero-extend, which gives the padding.
  localparam int FOLD_MAX = 1024;

  function automatic logic [31:0] fold32(input logic [FOLD_MAX-1:0] v);
    logic [31:0] acc;
    acc = '0;
    for (int c = 0; c < FOLD_MAX / 32; c++) acc ^= v[c*32 +: 32];
    return acc;
  endfunction

endpackage

// File: rtl/fuzz_lane_pipe_if.sv
// Valid/ready bus of the fuzz lane pipeline; master drives beats in, slave is the pipe.
interface fuzz_lane_pipe_if #(
  parameter int W     = 21,
  parameter int LANES = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic [LANES*W-1:0]   in_data;
  logic [1:0]           in_mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [LANES*W-1:0]   out_data;
  logic [LANES-1:0]     out_flag;
  logic [31:0]          sig;
  logic                 busy;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_flag, sig, busy
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_flag, sig, busy
  );
endinterface

// File: rtl/fuzz_lane_pipe_mix.sv
// Combinational stage-0 mix for one lane: a is this lane, b is the next lane around.
module fuzz_mix_lane
  import fuzz_pkg::*;
#(
  parameter int         W    = 21,
  parameter logic [7:0] SEED = 8'hA6
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  mode_e        mode,
  output logic [W-1:0] r,
  output logic         flag
);
  localparam logic [W-1:0] SEED_W = W'(SEED);

  always_comb begin
    r = a;
    unique case (mode)
      MODE_PASS: r = a;
      MODE_XOR:  r = a ^ b;
      MODE_SUB:  r = ($signed(a) > $signed(b)) ? a - b : b;
      MODE_ROT:  r = (~&a) ? {a[W-2:0], a[W-1]} : a ^ SEED_W;
    endcase
    flag = ~^r;
  end
endmodule

// File: rtl/fuzz_lane_pipe.sv
// Multi-lane mixing datapath: stage 0 mixes, later stages only register, valid/ready throughout.
// Define FUZZ_SIG_EN to build the running output signature; otherwise sig is tied to zero.
module fuzz_lane_pipe
  import fuzz_pkg::*;
#(
  parameter int         W     = 21,
  parameter int         LANES = 4,
  parameter int         DEPTH = 3,
  parameter logic [7:0] SEED  = 8'hA6
) (
  input  logic           clk,
  input  logic           rst_n,
  fuzz_lane_pipe_if.slave bus
);
  localparam int DW = LANES * W;

  logic [LANES-1:0][W-1:0] lane_in;
  logic [LANES-1:0][W-1:0] lane_mix;
  logic [LANES-1:0]        lane_flag;
  mode_e                   mode;

  assign lane_in = bus.in_data;
  assign mode    = mode_e'(bus.in_mode);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    fuzz_mix_lane #(.W(W), .SEED(SEED)) u_mix (
      .a    (lane_in[i]),
      .b    (lane_in[(i+1) % LANES]),
      .mode (mode),
      .r    (lane_mix[i]),
      .flag (lane_flag[i])
    );
  end

  logic [DEPTH-1:0]                vld_pipe;
  logic [DEPTH:0]                  rdy;
  logic [DEPTH-1:0][DW-1:0]        dat;
  logic [DEPTH-1:0][LANES-1:0]     flg;

  assign rdy[DEPTH] = bus.out_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic             src_v;
    logic [DW-1:0]    src_d;
    logic [LANES-1:0] src_f;
    logic             v;
    logic [DW-1:0]    d;
    logic [LANES-1:0] f;

    if (k == 0) begin : g_head
      assign src_v = bus.in_valid;
      assign src_d = lane_mix;
      assign src_f = lane_flag;
    end else begin : g_body
      assign src_v = vld_pipe[k-1];
      assign src_d = dat[k-1];
      assign src_f = flg[k-1];
    end

    // A stage is free when empty or when its content leaves this cycle, so bubbles collapse.
    assign rdy[k] = ~v | rdy[k+1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v <= 1'b0;
        d <= '0;
        f <= '0;
      end else if (rdy[k]) begin
        v <= src_v;
        if (src_v) begin
          d <= src_d;
          f <= src_f;
        end
      end
    end

    assign vld_pipe[k] = v;
    assign dat[k]      = d;
    assign flg[k]      = f;
  end

  assign bus.in_ready  = rdy[0];
  assign bus.out_valid = vld_pipe[DEPTH-1];
  assign bus.out_data  = dat[DEPTH-1];
  assign bus.out_flag  = flg[DEPTH-1];
  assign bus.busy      = |vld_pipe;

`ifdef FUZZ_SIG_EN
  logic [31:0] sig_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sig_q <= SIG_RESET;
    else if (vld_pipe[DEPTH-1] && bus.out_ready)
      sig_q <= {sig_q[30:0], sig_q[31]} ^ fold32(FOLD_MAX'(dat[DEPTH-1]));
  end

  assign bus.sig = sig_q;
`else
  assign bus.sig = '0;
`endif

endmodule

// File: tb/tb_fuzz_lane_pipe.sv
// Self-checking bench for fuzz_lane_pipe: directed vector table, stall/reset sequences, random traffic.
module tb_fuzz_lane_pipe;
  import fuzz_pkg::*;

  localparam int         W     = 21;
  localparam int         LANES = 4;
  localparam int         DEPTH = 3;
  localparam int         DW    = W * LANES;
  localparam logic [7:0] SEED  = 8'hA6;
`ifdef FUZZ_SIG_EN
  localparam bit SIG_ON = 1'b1;
`else
  localparam bit SIG_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fuzz_lane_pipe_if #(.W(W), .LANES(LANES)) bus ();

  fuzz_lane_pipe #(.W(W), .LANES(LANES), .DEPTH(DEPTH), .SEED(SEED)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference model, written from the lane rules with plain integer arithmetic.
  function automatic logic [W-1:0] ref_lane(input int mode, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, mod;
    mod = longint'(1) <<< W;
    sa  = a[W-1] ? longint'(a) - mod : longint'(a);
    sb  = b[W-1] ? longint'(b) - mod : longint'(b);
    case (mode)
      0: return a;
      1: return a ^ b;
      2: return (sa > sb) ? W'(sa - sb) : b;
      default: begin
        if (longint'(a) == mod - 1) return a ^ W'(SEED);
        return W'(((longint'(a) * 2) % mod) + (longint'(a) / (mod / 2)));
      end
    endcase
  endfunction

  function automatic logic [DW-1:0] ref_beat(input logic [DW-1:0] d, input int mode);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < LANES; i++)
      r[i*W +: W] = ref_lane(mode, d[i*W +: W], d[((i+1) % LANES)*W +: W]);
    return r;
  endfunction

  function automatic logic [LANES-1:0] ref_flags(input logic [DW-1:0] d);
    logic [LANES-1:0] f;
    for (int i = 0; i < LANES; i++) f[i] = ($countones(d[i*W +: W]) % 2) == 0;
    return f;
  endfunction

  function automatic logic [31:0] sig_next(input logic [31:0] s, input logic [DW-1:0] d);
    logic [31:0]   fold;
    logic [DW-1:0] t;
    fold = 32'h0;
    for (int c = 0; c * 32 < DW; c++) begin
      t = d >> (32 * c);
      fold ^= t[31:0];
    end
    return ((s << 1) | (s >> 31)) ^ fold;
  endfunction

  function automatic logic [DW-1:0] pack(input logic [W-1:0] l0, l1, l2, l3);
    return {l3, l2, l1, l0};
  endfunction

  logic [DW-1:0]    q_d[$];
  logic [31:0]      sig_m;
  bit               prev_stall;
  logic [DW-1:0]    prev_d;
  logic [LANES-1:0] prev_f;
  int               cyc, n_in, n_out, last_out_cyc, last_in_cyc;
  logic [DW-1:0]    last_out_d;

  // Inputs are set before calling; evaluation happens on the falling edge.
  task automatic tick();
    logic [DW-1:0] e;
    @(negedge clk);
    cyc++;
    if (prev_stall) begin
      check("stall_data", bus.out_data, prev_d);
      check("stall_flag", bus.out_flag, prev_f);
    end
    if (bus.out_valid && bus.out_ready) begin
      if (q_d.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_beat: got %h want none", bus.out_data);
      end else begin
        e = q_d.pop_front();
        check("out_data", bus.out_data, e);
        check("out_flag", bus.out_flag, ref_flags(e));
        sig_m = sig_next(sig_m, e);
      end
      n_out++;
      last_out_cyc = cyc;
      last_out_d   = bus.out_data;
    end
    if (bus.in_valid && bus.in_ready) begin
      q_d.push_back(ref_beat(bus.in_data, int'(bus.in_mode)));
      n_in++;
      last_in_cyc = cyc;
    end
    prev_stall = bus.out_valid && !bus.out_ready;
    prev_d     = bus.out_data;
    prev_f     = bus.out_flag;
    @(posedge clk);
    #1;
    check("sig", bus.sig, SIG_ON ? sig_m : 32'h0);
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #2;
    q_d.delete();
    sig_m      = SIG_RESET;
    prev_stall = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int            mode;
    logic [DW-1:0] din;
    logic [DW-1:0] dout;
  } vec_t;

  vec_t vt[6];

  initial begin
    int idx, b_in, b_out;
    logic [DW-1:0] beats[5];

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_mode   = 2'd0;
    bus.out_ready = 1'b1;
    sig_m         = SIG_RESET;
    prev_stall    = 1'b0;
    cyc = 0; n_in = 0; n_out = 0; last_out_cyc = 0; last_in_cyc = 0;

    #12;
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_in_ready",  bus.in_ready,  1'b1);
    check("rst_busy",      bus.busy,      1'b0);
    check("rst_out_data",  bus.out_data,  '0);
    check("rst_out_flag",  bus.out_flag,  '0);
    check("rst_sig",       bus.sig,       SIG_ON ? 32'hFFFF_FFFF : 32'h0);
    do_reset();

    vt[0] = '{0, pack(21'h1, 21'h0, 21'h0, 21'h0),            pack(21'h1, 21'h0, 21'h0, 21'h0)};
    vt[1] = '{1, pack(21'h1, 21'h2, 21'h4, 21'h8),            pack(21'h3, 21'h6, 21'hC, 21'h9)};
    vt[2] = '{2, pack(21'h1FFFFF, 21'h0, 21'h5, 21'h3),       pack(21'h0, 21'h5, 21'h2, 21'h4)};
    vt[3] = '{2, pack(21'h5, 21'h5, 21'h7, 21'h1),            pack(21'h5, 21'h7, 21'h6, 21'h5)};
    vt[4] = '{3, pack(21'h1FFFFF, 21'h0, 21'h0, 21'h0),       pack(21'h1FFF59, 21'h0, 21'h0, 21'h0)};
    vt[5] = '{3, pack(21'h100000, 21'h3, 21'h1FFFFF, 21'h0),  pack(21'h1, 21'h6, 21'h1FFF59, 21'h0)};

    for (int v = 0; v < 6; v++) begin
      b_in  = n_in;
      b_out = n_out;
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = vt[v].din;
      bus.in_mode   = 2'(vt[v].mode);
      tick();
      bus.in_valid = 1'b0;
      check("vec_accept", n_in - b_in, 1);
      for (int t = 0; t < 10 && n_out == b_out; t++) tick();
      check("vec_latency", last_out_cyc - last_in_cyc, DEPTH);
      check("vec_data", last_out_d, vt[v].dout);
      if (v == 0) check("sig_first", bus.sig, SIG_ON ? 32'hFFFF_FFFE : 32'h0);
    end

    // Output blocked: only DEPTH beats fit, output must hold steady.
    for (int i = 0; i < 5; i++) beats[i] = DW'({$urandom, $urandom, $urandom});
    bus.out_ready = 1'b0;
    bus.in_mode   = 2'd1;
    idx  = 0;
    b_out = n_out;
    for (int t = 0; t < 5; t++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = beats[idx];
      b_in = n_in;
      tick();
      if (n_in != b_in) idx++;
    end
    check("stall_accepted", idx, DEPTH);
    check("stall_in_ready", bus.in_ready, 1'b0);
    check("stall_busy", bus.busy, 1'b1);
    bus.out_ready = 1'b1;
    for (int t = 0; t < 30 && n_out - b_out < 5; t++) begin
      bus.in_valid = (idx < 5);
      bus.in_data  = beats[idx < 5 ? idx : 4];
      b_in = n_in;
      tick();
      if (n_in != b_in) idx++;
    end
    bus.in_valid = 1'b0;
    check("drain_count", n_out - b_out, 5);
    check("drain_empty", q_d.size(), 0);

    // Reset with beats in flight: nothing may emerge afterwards.
    bus.out_ready = 1'b0;
    bus.in_mode   = 2'd0;
    for (int t = 0; t < 2; t++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = DW'({$urandom, $urandom, $urandom});
      tick();
    end
    bus.in_valid = 1'b0;
    check("inflight_valid", bus.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", bus.out_valid, 1'b0);
    check("rst_mid_busy", bus.busy, 1'b0);
    check("rst_mid_sig", bus.sig, SIG_ON ? 32'hFFFF_FFFF : 32'h0);
    do_reset();
    bus.out_ready = 1'b1;
    b_out = n_out;
    for (int t = 0; t < 10; t++) tick();
    check("rst_no_stale", n_out - b_out, 0);

    // Random traffic against the scoreboard.
    for (int t = 0; t < 600; t++) begin
      bus.in_valid  = ($urandom_range(0, 9) < 7);
      bus.out_ready = ($urandom_range(0, 9) < 6);
      bus.in_mode   = 2'($urandom_range(0, 3));
      bus.in_data   = DW'({$urandom, $urandom, $urandom});
      if ($urandom_range(0, 3) == 0) bus.in_data[W-1:0] = '1;
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 20 && q_d.size() != 0; t++) tick();
    check("random_drain", q_d.size(), 0);
    check("random_idle", bus.busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
